fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch and program-counter stage that sits directly upstream of the control unit.
- Holds the PC, requests instructions from instruction memory and latches them into the instruction register (IR) that feeds the control unit.
- Applies the control word's PS field to choose the next PC.
- Holds the V/C/Z/N status register that the control unit reads for B.cond and CBZ/CBNZ.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- PS  in  2  PC select from the control word: 00 hold, 01 PC+4, 10 load A_bus, 11 PC+(K<<2).
- K  in  64  branch offset in words, taken as 64-bit two's complement; the control unit sign-extends it.
- A_bus  in  64  register-file port A, the BR target.
- SL  in  1  status load enable.
- alu_status  in  4  {V,C,Z,N} from the ALU.
- imem_addr  out  64  fetch address, equal to pc.
- imem_req  out  1  fetch request.
- imem_rdata  in  32  instruction word.
- imem_valid  in  1  imem_rdata valid.
- instruction  out  32  IR contents, to the control unit.
- exec_valid  out  1  high in EXEC; the datapath gates regW/ramW with it.
- pc  out  64  address of the instruction in IR.
- pc_plus4  out  64  pc+4, the BL link value.
- status  out  4  {V,C,Z,N}, to the control unit.

Behaviour:
Reset, on a clock edge with reset=1:
- state=FETCH, pc=RESET_PC, instruction=32'h0, status=4'h0.
- While reset=1, exec_valid=0 and imem_req=0.
- imem_valid is ignored while reset=1.
- Reset mid-fetch or mid-EXEC aborts the operation: no PC update and no status update on that edge.

States: FETCH, EXEC, plus HALT (only when the optional feature is compiled in).

FETCH:
- imem_req=1, imem_addr=pc, held stable until accepted.
- When imem_valid=1 at an edge: instruction<=imem_rdata, then go to EXEC.
- When imem_valid=0: stay in FETCH with no change.
- Best case, imem_valid arrives in the first FETCH cycle, giving 2 cycles per instruction.

EXEC:
- exec_valid=1, imem_req=0. The control word is valid combinationally from instruction and status.
- At the edge, by PS:
  - 00: pc unchanged, IR unchanged, stay in EXEC. This gives a multi-cycle instruction (e.g. a two-pass MOVK/MOVZ) a further EXEC cycle.
  - 01: pc<=pc+4, go to FETCH.
  - 10: pc<=A_bus, go to FETCH.
  - 11: pc<=pc+(K<<2), go to FETCH.
- If SL=1, status<=alu_status at the same edge, independent of PS.

Other rules:
- imem_valid outside FETCH is ignored.
- SL outside EXEC is ignored.
- All PC arithmetic is modulo 2^64; wrap-around is silent (e.g. 64'hFFFF_FFFF_FFFF_FFFC+4 = 0).
- K<<2 discards K[63:62].
- pc_plus4 is combinational pc+4 and wraps the same way.
- PC updates only at the EXEC edge, so B.cond/CBZ outcomes use the status value registered before that edge.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - In EXEC, PS=10 with A_bus[1:0]!=2'b00, or PS=11 producing a target with bits[1:0]!=0, does not update pc.
  - The block enters HALT and sets extra output port align_fault (1 bit, reset 0).
  - HALT keeps imem_req=0 and exec_valid=0, and is left only by reset.
  - align_fault is sticky until reset.
- Undefined: no HALT state and no align_fault port; any misaligned target is loaded into pc unchanged.

Test Plan:
1. Reset with RESET_PC=64'h100, release reset, imem_valid=1 on the first FETCH cycle with rdata=32'h8B020020, then PS=01 -> the edge accepting imem_valid loads instruction=32'h8B020020, the next cycle has exec_valid=1 and pc=64'h100, then pc=64'h104 and back in FETCH with imem_req=1, imem_addr=64'h104.
2. imem_valid held low for 3 cycles in FETCH -> imem_req=1 and imem_addr stable for all 3 cycles, IR unchanged, exec_valid=0 throughout.
3. pc=64'h200, PS=11, K=64'hFFFF_FFFF_FFFF_FFFE (-2) -> pc=64'h1F8. With K=64'h10 instead -> pc=64'h240.
4. PS=00 for 2 EXEC cycles, then PS=10 with A_bus=64'h3000 and SL=1, alu_status=4'b0010 -> pc/IR held for 2 cycles, then pc=64'h3000 and status=4'b0010.
5. Reset asserted in EXEC with PS=01 and SL=1 -> pc=RESET_PC, status=0, state=FETCH; no pc+4 and no status load.
6. With FETCH_ALIGN_CHECK_EN: PS=10, A_bus=64'h3002 -> pc unchanged, align_fault=1, imem_req stays 0 through 10 idle cycles. Without the macro -> pc=64'h3002.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch handshake between fetch_unit (master) and imem (slave).
interface fetch_unit_if;
    logic [63:0] addr;
    logic        req;
    logic [31:0] rdata;
    logic        valid;

    modport master (output addr, output req, input rdata, input valid);
    modport slave  (input addr, input req, output rdata, output valid);
endinterface

// File: rtl/fetch_unit.sv
// PC / IR / status stage feeding the control unit: FETCH -> EXEC loop with PS-driven next PC.
// Optional macro FETCH_ALIGN_CHECK_EN adds a HALT state and the align_fault port for misaligned branches.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic               clock,
    input  logic               reset,
    fetch_unit_if.master       imem,
    input  logic [1:0]         PS,
    input  logic [63:0]        K,
    input  logic [63:0]        A_bus,
    input  logic               SL,
    input  logic [3:0]         alu_status,
    output logic [31:0]        instruction,
    output logic               exec_valid,
    output logic [63:0]        pc,
    output logic [63:0]        pc_plus4,
    output logic [3:0]         status
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic               align_fault
`endif
);
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] pc_next;

    // Next-PC candidate selected by PS; all arithmetic wraps modulo 2^64.
    always_comb begin
        pc_next = pc;
        case (PS)
            2'b01:   pc_next = pc + 64'd4;
            2'b10:   pc_next = A_bus;
            2'b11:   pc_next = pc + (K << 2);
            default: pc_next = pc;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = PS[1] && (pc_next[1:0] != 2'b00);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instruction <= 32'h0;
            status      <= 4'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            align_fault <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem.valid) begin
                        instruction <= imem.rdata;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (SL)
                        status <= alu_status;
                    // PS=00 keeps the instruction in EXEC for another pass.
                    if (PS != 2'b00) begin
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misaligned) begin
                            state       <= S_HALT;
                            align_fault <= 1'b1;
                        end else begin
                            pc    <= pc_next;
                            state <= S_FETCH;
                        end
`else
                        pc    <= pc_next;
                        state <= S_FETCH;
`endif
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Strobes decoded from the state register, forced low while reset is held.
    assign imem.req   = ~reset & (state == S_FETCH);
    assign exec_valid = ~reset & (state == S_EXEC);
    assign imem.addr  = pc;
    assign pc_plus4   = pc + 64'd4;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle model comparison plus hand-computed literal checks.
module tb_fetch_unit;
    localparam logic [63:0] RST_PC = 64'h100;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  PS = 2'b00;
    logic [63:0] K = 64'h0;
    logic [63:0] A_bus = 64'h0;
    logic        SL = 1'b0;
    logic [3:0]  alu_status = 4'h0;
    logic [31:0] instruction;
    logic        exec_valid;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic [3:0]  status;
    logic        align_fault_w;

    fetch_unit_if imem_bus();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem        (imem_bus.master),
        .PS          (PS),
        .K           (K),
        .A_bus       (A_bus),
        .SL          (SL),
        .alu_status  (alu_status),
        .instruction (instruction),
        .exec_valid  (exec_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .status      (status)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .align_fault (align_fault_w)
`endif
    );
`ifndef FETCH_ALIGN_CHECK_EN
    assign align_fault_w = 1'b0;
`endif

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: where the machine is, and what the next PC should be.
    bit          m_exec, m_halt, m_fault;
    logic [63:0] m_pc;
    logic [31:0] m_ir;
    logic [3:0]  m_st;

    function automatic logic [63:0] target(input logic [1:0] ps, input logic [63:0] cur,
                                           input logic [63:0] a, input logic [63:0] k);
        case (ps)
            2'b01:   return cur + 64'd4;
            2'b10:   return a;
            2'b11:   return cur + k * 64'd4;
            default: return cur;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_exec <= 1'b0; m_halt <= 1'b0; m_fault <= 1'b0;
            m_pc <= RST_PC; m_ir <= 32'h0; m_st <= 4'h0;
        end else if (m_halt) begin
            m_halt <= 1'b1;
        end else if (!m_exec) begin
            if (imem_bus.valid) begin
                m_ir   <= imem_bus.rdata;
                m_exec <= 1'b1;
            end
        end else begin
            if (SL) m_st <= alu_status;
            if (PS != 2'b00) begin
                if (ALIGN_EN && PS[1] && (target(PS, m_pc, A_bus, K) % 64'd4 != 64'd0)) begin
                    m_halt  <= 1'b1;
                    m_fault <= 1'b1;
                    m_exec  <= 1'b0;
                end else begin
                    m_pc   <= target(PS, m_pc, A_bus, K);
                    m_exec <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison, sampled mid-cycle.
    always @(negedge clock) begin
        if (chk_on) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_bus.addr, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 64'd4);
            chk("instruction", 64'(instruction), 64'(m_ir));
            chk("status", 64'(status), 64'(m_st));
            chk("exec_valid", 64'(exec_valid), 64'(!reset && m_exec && !m_halt));
            chk("imem_req", 64'(imem_bus.req), 64'(!reset && !m_exec && !m_halt));
            chk("align_fault", 64'(align_fault_w), 64'(m_fault));
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        imem_bus.valid = 1'b0;
        imem_bus.rdata = 32'h0;

        // Reset state
        tick; chk_on = 1'b1; tick;
        chk("rst_pc", pc, 64'h100);
        chk("rst_ir", 64'(instruction), 64'h0);
        chk("rst_status", 64'(status), 64'h0);
        chk("rst_req", 64'(imem_bus.req), 64'h0);
        chk("rst_exec", 64'(exec_valid), 64'h0);

        // 1: single fetch then PC+4
        reset = 1'b0; #1;
        chk("t1_req_after_rst", 64'(imem_bus.req), 64'h1);
        imem_bus.valid = 1'b1; imem_bus.rdata = 32'h8B02_0020; PS = 2'b01;
        tick;
        chk("t1_ir", 64'(instruction), 64'h8B02_0020);
        chk("t1_exec", 64'(exec_valid), 64'h1);
        chk("t1_pc", pc, 64'h100);
        chk("t1_req_exec", 64'(imem_bus.req), 64'h0);
        imem_bus.valid = 1'b0;
        tick;
        chk("t1_pc4", pc, 64'h104);
        chk("t1_req", 64'(imem_bus.req), 64'h1);
        chk("t1_addr", imem_bus.addr, 64'h104);

        // 2: memory stall in FETCH; SL is ignored here
        SL = 1'b1; alu_status = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t2_req", 64'(imem_bus.req), 64'h1);
            chk("t2_addr", imem_bus.addr, 64'h104);
            chk("t2_ir", 64'(instruction), 64'h8B02_0020);
            chk("t2_exec", 64'(exec_valid), 64'h0);
        end
        chk("t2_status", 64'(status), 64'h0);
        SL = 1'b0;

        // 3: relative branches from 0x200
        imem_bus.valid = 1'b1; tick;
        imem_bus.valid = 1'b0; PS = 2'b10; A_bus = 64'h200; tick;
        imem_bus.valid = 1'b1; tick;
        imem_bus.valid = 1'b0; PS = 2'b11; K = 64'hFFFF_FFFF_FFFF_FFFE; tick;
        chk("t3_back", pc, 64'h1F8);
        imem_bus.valid = 1'b1; tick;
        imem_bus.valid = 1'b0; PS = 2'b10; A_bus = 64'h200; tick;
        imem_bus.valid = 1'b1; tick;
        imem_bus.valid = 1'b0; PS = 2'b11; K = 64'h10; tick;
        chk("t3_fwd", pc, 64'h240);

        // 4: two-pass EXEC, then BR with status load; imem_valid in EXEC ignored
        imem_bus.valid = 1'b1; imem_bus.rdata = 32'hD280_0001; tick;
        imem_bus.rdata = 32'hDEAD_BEEF; PS = 2'b00;
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("t4_pc_hold", pc, 64'h240);
            chk("t4_ir_hold", 64'(instruction), 64'hD280_0001);
            chk("t4_exec", 64'(exec_valid), 64'h1);
        end
        imem_bus.valid = 1'b0; PS = 2'b10; A_bus = 64'h3000; SL = 1'b1; alu_status = 4'b0010;
        tick;
        chk("t4_pc", pc, 64'h3000);
        chk("t4_status", 64'(status), 64'h2);
        SL = 1'b0;

        // Wrap-around of pc+4
        imem_bus.valid = 1'b1; tick;
        imem_bus.valid = 1'b0; A_bus = 64'hFFFF_FFFF_FFFF_FFFC; tick;
        chk("wrap_plus4", pc_plus4, 64'h0);
        imem_bus.valid = 1'b1; tick;
        imem_bus.valid = 1'b0; PS = 2'b01; tick;
        chk("wrap_pc", pc, 64'h0);

        // 5: reset in EXEC aborts PC and status update
        imem_bus.valid = 1'b1; tick;
        imem_bus.valid = 1'b0; PS = 2'b01; SL = 1'b1; alu_status = 4'hF; reset = 1'b1;
        tick;
        chk("t5_pc", pc, 64'h100);
        chk("t5_status", 64'(status), 64'h0);
        chk("t5_exec", 64'(exec_valid), 64'h0);
        chk("t5_req", 64'(imem_bus.req), 64'h0);
        reset = 1'b0; SL = 1'b0; #1;
        chk("t5_fetch_req", 64'(imem_bus.req), 64'h1);
        chk("t5_addr", imem_bus.addr, 64'h100);

        // 6: misaligned BR target
        imem_bus.valid = 1'b1; tick;
        imem_bus.valid = 1'b0; PS = 2'b10; A_bus = 64'h3002; tick;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_pc_kept", pc, 64'h100);
        chk("t6_fault", 64'(align_fault_w), 64'h1);
        imem_bus.valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t6_halt_req", 64'(imem_bus.req), 64'h0);
            chk("t6_halt_exec", 64'(exec_valid), 64'h0);
        end
        chk("t6_fault_sticky", 64'(align_fault_w), 64'h1);
`else
        chk("t6_pc_loaded", pc, 64'h3002);
        chk("t6_req", 64'(imem_bus.req), 64'h1);
`endif
        imem_bus.valid = 1'b0;
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
